// File: rtl/crossbar_pkg.sv
// crossbar_pkg: constants and helpers shared by the crossbar request and
// response paths.
//   N_SRC / N_DST : number of initiators / targets
//   ID_W          : width of the initiator id carried with each response
//   ID_ILLEGAL    : the one id value that names no initiator
//   RSP_PLD_W     : default response payload width, sizes rsp_t
//   rr_pick       : two-way round-robin pick between the targets
package crossbar_pkg;

  localparam int N_SRC = 32'd3;
  localparam int N_DST = 32'd2;
  localparam int ID_W = 32'd2;
  localparam logic [ID_W-1:0] ID_ILLEGAL = 2'd3;
  localparam int RSP_PLD_W = 32'd4;

  typedef struct packed {
    logic [RSP_PLD_W-1:0] pld;
  } rsp_t;

  // With a single requester it wins outright; with both, rr names the winner.
  function automatic logic [N_DST-1:0] rr_pick(input logic [N_DST-1:0] req,
                                               input logic rr);
    logic [N_DST-1:0] gnt;
    case (req)
      2'b11:   gnt = rr ? 2'b10 : 2'b01;
      default: gnt = req;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// rsp_fifo2: 2-entry valid/ready FIFO with a registered output side.
//   clk, rst          : clock, asynchronous active-high reset
//   push_vld/pld/rdy  : write side; push_rdy is low while full
//   pop_vld/pld/rdy   : read side; pop_vld is a flop, pop_pld is the head entry
// Fullness is taken from the start-of-cycle count, so a pop in the same cycle
// does not free a slot for a push.
module rsp_fifo2 #(
  parameter int PLD_W = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [PLD_W-1:0] push_pld,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [PLD_W-1:0] pop_pld,
  input  logic             pop_rdy
);

  logic [PLD_W-1:0] mem_r [2];
  logic             wptr_r;
  logic             rptr_r;
  logic [1:0]       cnt_r;
  logic             vld_r;
  logic             push_s;
  logic             pop_s;
  logic [1:0]       cnt_nxt_s;

  assign push_rdy = (cnt_r != 2'd2);
  assign push_s   = push_vld & push_rdy;
  assign pop_s    = vld_r & pop_rdy;
  assign pop_vld  = vld_r;
  assign pop_pld  = mem_r[rptr_r];

  // Occupancy after this cycle's push/pop; push+pop leaves the count unchanged.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + 2'd1;
      2'b01:   cnt_nxt_s = cnt_r - 2'd1;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Storage, 1-bit wrapping pointers, occupancy and the registered valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= {PLD_W{1'b0}};
      mem_r[1] <= {PLD_W{1'b0}};
      wptr_r   <= 1'b0;
      rptr_r   <= 1'b0;
      cnt_r    <= 2'd0;
      vld_r    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= push_pld;
        wptr_r        <= ~wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ~rptr_r;
      end
      cnt_r <= cnt_nxt_s;
      vld_r <= (cnt_nxt_s != 2'd0);
    end
  end

endmodule

// File: rtl/crossbar_rsp_mton.sv
// crossbar_rsp_mton: response return path, 2 targets -> 3 initiators.
//   clk, rst                    : clock, asynchronous active-high reset
//   vld/pld/id_dst0..1, rdy_dst : target responses; id selects the initiator
//   vld/pld_src0..2, rdy_src    : registered initiator outputs (2-entry buffers)
//   err_id                      : sticky, an id-3 response was dropped
//   err_cnt                     : saturating count of dropped responses
module crossbar_rsp_mton
  import crossbar_pkg::*;
#(
  parameter int PLD_W     = RSP_PLD_W,
  parameter int ERR_CNT_W = 32'd8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_dst0,
  input  logic                 vld_dst1,
  input  logic [PLD_W-1:0]     pld_dst0,
  input  logic [PLD_W-1:0]     pld_dst1,
  input  logic [1:0]           id_dst0,
  input  logic [1:0]           id_dst1,
  output logic                 rdy_dst0,
  output logic                 rdy_dst1,
  output logic                 vld_src0,
  output logic                 vld_src1,
  output logic                 vld_src2,
  output logic [PLD_W-1:0]     pld_src0,
  output logic [PLD_W-1:0]     pld_src1,
  output logic [PLD_W-1:0]     pld_src2,
  input  logic                 rdy_src0,
  input  logic                 rdy_src1,
  input  logic                 rdy_src2,
  output logic                 err_id,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [N_DST-1:0] vld_s;
  logic [ID_W-1:0]  id_s      [N_DST];
  logic [PLD_W-1:0] pld_s     [N_DST];
  logic [N_DST-1:0] req_s     [N_SRC];
  logic [N_DST-1:0] gnt_s     [N_SRC];
  logic [N_SRC-1:0] fifo_rdy_s;
  logic [N_SRC-1:0] push_vld_s;
  logic [PLD_W-1:0] push_pld_s[N_SRC];
  logic [N_SRC-1:0] src_vld_s;
  logic [PLD_W-1:0] src_pld_s [N_SRC];
  logic [N_SRC-1:0] src_rdy_s;
  logic [N_DST-1:0] illegal_s;
  logic [N_DST-1:0] drop_s;
  logic [N_DST-1:0] dst_rdy_s;
  logic [1:0]       drop_inc_s;
  logic [ERR_CNT_W:0] err_sum_s;
  logic [N_SRC-1:0] rr_r;
  logic             err_id_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  assign vld_s     = {vld_dst1, vld_dst0};
  assign id_s[0]   = id_dst0;
  assign id_s[1]   = id_dst1;
  assign pld_s[0]  = pld_dst0;
  assign pld_s[1]  = pld_dst1;
  assign src_rdy_s = {rdy_src2, rdy_src1, rdy_src0};

  // Per-initiator id decode and round-robin; no grant into a full buffer.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      for (int j = 0; j < N_DST; j++) begin
        req_s[i][j] = vld_s[j] & (id_s[j] == ID_W'(i));
      end
      if (!rst && fifo_rdy_s[i]) begin
        gnt_s[i] = rr_pick(req_s[i], rr_r[i]);
      end else begin
        gnt_s[i] = {N_DST{1'b0}};
      end
      push_vld_s[i] = |gnt_s[i];
      push_pld_s[i] = gnt_s[i][1] ? pld_s[1] : pld_s[0];
    end
  end

  // Target-side ready: granted somewhere, or an illegal id that is swallowed.
  always_comb begin
    for (int j = 0; j < N_DST; j++) begin
      illegal_s[j] = (id_s[j] == ID_ILLEGAL);
      dst_rdy_s[j] = !rst & (gnt_s[0][j] | gnt_s[1][j] | gnt_s[2][j] | illegal_s[j]);
      drop_s[j]    = !rst & vld_s[j] & illegal_s[j];
    end
  end

  assign rdy_dst0   = dst_rdy_s[0];
  assign rdy_dst1   = dst_rdy_s[1];
  assign drop_inc_s = {1'b0, drop_s[0]} + {1'b0, drop_s[1]};
  // One spare bit catches the wrap so the counter can saturate.
  assign err_sum_s  = {1'b0, err_cnt_r} + {{(ERR_CNT_W-1){1'b0}}, drop_inc_s};

  // Round-robin pointers: the loser of the last accepted grant goes first next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r <= {N_SRC{1'b0}};
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push_vld_s[i]) begin
          rr_r[i] <= gnt_s[i][0];
        end
      end
    end
  end

  // Sticky illegal-id flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_id_r  <= 1'b0;
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else begin
      if (|drop_s) begin
        err_id_r <= 1'b1;
      end
      if (err_sum_s[ERR_CNT_W]) begin
        err_cnt_r <= {ERR_CNT_W{1'b1}};
      end else begin
        err_cnt_r <= err_sum_s[ERR_CNT_W-1:0];
      end
    end
  end

  assign err_id  = err_id_r;
  assign err_cnt = err_cnt_r;

  for (genvar i = 0; i < N_SRC; i++) begin : g_buf
    rsp_fifo2 #(.PLD_W(PLD_W)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .push_vld (push_vld_s[i]),
      .push_pld (push_pld_s[i]),
      .push_rdy (fifo_rdy_s[i]),
      .pop_vld  (src_vld_s[i]),
      .pop_pld  (src_pld_s[i]),
      .pop_rdy  (src_rdy_s[i])
    );
  end

  assign vld_src0 = src_vld_s[0];
  assign vld_src1 = src_vld_s[1];
  assign vld_src2 = src_vld_s[2];
  assign pld_src0 = src_pld_s[0];
  assign pld_src1 = src_pld_s[1];
  assign pld_src2 = src_pld_s[2];

endmodule

// File: tb/tb_crossbar_rsp_mton.sv
// Self-checking bench for crossbar_rsp_mton: a small reference model predicts
// target-side ready, pushes expected payloads into per-initiator queues when
// a response is accepted, and pops/compares when an initiator takes one.
module tb_crossbar_rsp_mton;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld_dst0 = 1'b0, vld_dst1 = 1'b0;
  logic [3:0] pld_dst0 = 4'd0, pld_dst1 = 4'd0;
  logic [1:0] id_dst0 = 2'd0, id_dst1 = 2'd0;
  logic       rdy_dst0, rdy_dst1;
  logic       vld_src0, vld_src1, vld_src2;
  logic [3:0] pld_src0, pld_src1, pld_src2;
  logic [2:0] rdy_s = 3'b000;
  logic       err_id;
  logic [7:0] err_cnt;

  crossbar_rsp_mton #(.PLD_W(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .vld_dst0(vld_dst0), .vld_dst1(vld_dst1),
    .pld_dst0(pld_dst0), .pld_dst1(pld_dst1),
    .id_dst0(id_dst0), .id_dst1(id_dst1),
    .rdy_dst0(rdy_dst0), .rdy_dst1(rdy_dst1),
    .vld_src0(vld_src0), .vld_src1(vld_src1), .vld_src2(vld_src2),
    .pld_src0(pld_src0), .pld_src1(pld_src1), .pld_src2(pld_src2),
    .rdy_src0(rdy_s[0]), .rdy_src1(rdy_s[1]), .rdy_src2(rdy_s[2]),
    .err_id(err_id), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [2:0] vld_o;
  logic [3:0] pld_o [3];
  assign vld_o    = {vld_src2, vld_src1, vld_src0};
  assign pld_o[0] = pld_src0;
  assign pld_o[1] = pld_src1;
  assign pld_o[2] = pld_src2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference model state
  int         m_cnt [3];
  bit         m_rr  [3];
  bit         m_err_id;
  int         m_err_cnt;
  logic [3:0] sbq [3][$];
  bit         m_g0, m_g1;   // dst0 / dst1 accepted by a buffer this cycle
  int         acc0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_rr[i]  = 1'b0;
      sbq[i].delete();
    end
    m_err_id  = 1'b0;
    m_err_cnt = 0;
  endtask

  // Check one cycle against the model, then advance model and DUT one edge.
  task automatic cycle();
    bit r0, r1, e0, e1, ill0, ill1;
    bit g [3][2];
    int inc;
    #1;
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r0 = vld_dst0 && (id_dst0 == 2'(i));
      r1 = vld_dst1 && (id_dst1 == 2'(i));
      g[i][0] = 1'b0;
      g[i][1] = 1'b0;
      if (!rst && m_cnt[i] < 2) begin
        if (r0 && r1) begin
          g[i][0] = (m_rr[i] == 1'b0);
          g[i][1] = (m_rr[i] == 1'b1);
        end else begin
          g[i][0] = r0;
          g[i][1] = r1;
        end
      end
      m_g0 |= g[i][0];
      m_g1 |= g[i][1];
    end
    ill0 = (id_dst0 == 2'd3);
    ill1 = (id_dst1 == 2'd3);
    e0 = !rst && (m_g0 || ill0);
    e1 = !rst && (m_g1 || ill1);
    chk("rdy_dst0", 32'(rdy_dst0), 32'(e0));
    chk("rdy_dst1", 32'(rdy_dst1), 32'(e1));
    acc0 += int'(rdy_dst0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("vld_src%0d", i), 32'(vld_o[i]), 32'(m_cnt[i] != 0));
      if (m_cnt[i] != 0) begin
        chk($sformatf("pld_src%0d", i), 32'(pld_o[i]), 32'(sbq[i][0]));
      end else if (rst) begin
        chk($sformatf("pld_src%0d_rst", i), 32'(pld_o[i]), 32'd0);
      end
    end
    chk("err_id", 32'(err_id), 32'(m_err_id));
    chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
    // model update at the edge
    if (rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_cnt[i] != 0 && rdy_s[i]) begin
          void'(sbq[i].pop_front());
          m_cnt[i]--;
        end
        if (g[i][0] || g[i][1]) begin
          sbq[i].push_back(g[i][1] ? pld_dst1 : pld_dst0);
          m_cnt[i]++;
          m_rr[i] = g[i][0];
        end
      end
      inc = int'(vld_dst0 && ill0) + int'(vld_dst1 && ill1);
      if (inc != 0) m_err_id = 1'b1;
      m_err_cnt = (m_err_cnt + inc > 255) ? 255 : m_err_cnt + inc;
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] d0, d1;

  initial begin
    model_clear();
    acc0 = 0;
    // reset held with both targets valid
    @(posedge clk); #1;
    rst = 1'b1; vld_dst0 = 1'b1; vld_dst1 = 1'b1; id_dst0 = 2'd0; id_dst1 = 2'd1;
    repeat (3) cycle();
    vld_dst0 = 1'b0; vld_dst1 = 1'b0;
    rst = 1'b0;
    cycle();

    // single path dst0 -> initiator 2
    rdy_s = 3'b100;
    vld_dst0 = 1'b1; pld_dst0 = 4'hA; id_dst0 = 2'd2;
    cycle();
    vld_dst0 = 1'b0;
    chk("single_lat_vld2", 32'(vld_src2), 32'd1);
    chk("single_lat_pld2", 32'(pld_src2), 32'hA);
    repeat (2) cycle();

    // contention on initiator 1: expected order 1, 8, 2, 9
    rdy_s = 3'b010;
    d0 = 4'h1; d1 = 4'h8;
    vld_dst0 = 1'b1; vld_dst1 = 1'b1; id_dst0 = 2'd1; id_dst1 = 2'd1;
    for (int k = 0; k < 6; k++) begin
      pld_dst0 = d0; pld_dst1 = d1;
      cycle();
      if (m_g0) d0 = d0 + 4'd1;
      if (m_g1) d1 = d1 + 4'd1;
    end
    vld_dst0 = 1'b0; vld_dst1 = 1'b0;
    repeat (3) cycle();

    // back-pressure on initiator 0
    rdy_s = 3'b000;
    d0 = 4'h3; acc0 = 0;
    vld_dst0 = 1'b1; id_dst0 = 2'd0;
    for (int k = 0; k < 5; k++) begin
      pld_dst0 = d0;
      cycle();
      if (m_g0) d0 = d0 + 4'd1;
    end
    chk("bp_accepted", 32'(acc0), 32'd2);
    vld_dst0 = 1'b0; rdy_s = 3'b001;
    repeat (4) cycle();
    chk("bp_drained", 32'(vld_src0), 32'd0);

    // illegal id: two double drops, then dst1 alone long enough to saturate
    vld_dst0 = 1'b1; id_dst0 = 2'd3; vld_dst1 = 1'b1; id_dst1 = 2'd3;
    repeat (2) cycle();
    vld_dst0 = 1'b0;
    repeat (300) cycle();
    vld_dst1 = 1'b0;
    chk("err_id_sticky", 32'(err_id), 32'd1);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // fill every buffer to 2 entries with no initiator ready
    rdy_s = 3'b000;
    vld_dst0 = 1'b1; id_dst0 = 2'd0; pld_dst0 = 4'hC;
    vld_dst1 = 1'b1; id_dst1 = 2'd1; pld_dst1 = 4'hD;
    repeat (2) cycle();
    vld_dst1 = 1'b0; id_dst0 = 2'd2; pld_dst0 = 4'hE;
    repeat (2) cycle();
    vld_dst0 = 1'b0;
    cycle();
    // asynchronous reset mid-cycle: outputs drop without a clock edge
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("async_rst_vld0", 32'(vld_src0), 32'd0);
    chk("async_rst_vld1", 32'(vld_src1), 32'd0);
    chk("async_rst_vld2", 32'(vld_src2), 32'd0);
    chk("async_rst_err", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    rdy_s = 3'b001;
    vld_dst0 = 1'b1; id_dst0 = 2'd0; pld_dst0 = 4'h5;
    cycle();
    vld_dst0 = 1'b0;
    chk("post_rst_vld0", 32'(vld_src0), 32'd1);
    chk("post_rst_pld0", 32'(pld_src0), 32'h5);
    repeat (2) cycle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
